// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package if_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    WAIT    = S_WAIT,
    DISCARD = S_DISCARD
  } fetchState_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, PC+4} pairs; flush empties it in one cycle.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetchEntry_t              pushData,
  output fetchEntry_t              head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetchEntry_t      mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: the head is masked by the caller whenever count is zero.
  always_ff @(posedge Clk) begin
    if (push && !flush) mem[wrPtr] <= pushData;
  end

  assign head = mem[rdPtr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch front end: owns the fetch PC, keeps one request outstanding to instruction
// memory and queues returned instructions ahead of IF/ID.
//   state   | meaning
//   IDLE    | no request outstanding (queue full or just reset)
//   WAIT    | request at MemAddr outstanding, reply will be queued
//   DISCARD | stale request outstanding after a redirect, reply will be dropped
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Stall,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemData,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4
);

  localparam int              CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetchState_t      state;
  fetchState_t      stateNext;
  logic [31:0]      fetchPC;
  logic [31:0]      fetchPCNext;
  logic [31:0]      memAddrQ;
  logic [31:0]      memAddrNext;
  logic [31:0]      addrPlus4;
  logic [CNT_W-1:0] queueCount;
  logic [CNT_W-1:0] countNext;
  logic             push;
  logic             pop;
  logic             queueValid;
  fetchEntry_t      pushEntry;
  fetchEntry_t      headEntry;

  assign queueValid = (queueCount != '0);
  assign pop        = queueValid && !Stall && !Redirect;
  assign push       = MemAck && (state == WAIT) && !Redirect;
  assign countNext  = queueCount + CNT_W'(push) - CNT_W'(pop);
  assign addrPlus4  = memAddrQ + 32'd4;
  assign pushEntry  = '{instr: MemData, pcPlus4: addrPlus4};

  fetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .push     (push),
    .pop      (pop),
    .flush    (Redirect),
    .pushData (pushEntry),
    .head     (headEntry),
    .count    (queueCount)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      fetchPC  <= RESET_PC;
      memAddrQ <= RESET_PC;
    end else begin
      state    <= stateNext;
      fetchPC  <= fetchPCNext;
      memAddrQ <= memAddrNext;
    end
  end

  always_comb begin
    stateNext   = state;
    fetchPCNext = fetchPC;
    memAddrNext = memAddrQ;
    case (state)
      IDLE: begin
        if (Redirect) begin
          fetchPCNext = RedirectPC;
        end else if (queueCount < FULL) begin
          memAddrNext = fetchPC;
          stateNext   = WAIT;
        end
      end
      WAIT: begin
        if (Redirect) begin
          fetchPCNext = RedirectPC;
          if (MemAck) memAddrNext = RedirectPC;
          else        stateNext   = DISCARD;
        end else if (MemAck) begin
          fetchPCNext = addrPlus4;
          // Chain only while the queue still has room after this cycle's push/pop.
          if (countNext < FULL) memAddrNext = addrPlus4;
          else                  stateNext   = IDLE;
        end
      end
      DISCARD: begin
        if (Redirect) fetchPCNext = RedirectPC;
        if (MemAck) begin
          memAddrNext = Redirect ? RedirectPC : fetchPC;
          stateNext   = WAIT;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign MemReq      = (state != IDLE);
  assign MemAddr     = memAddrQ;
  assign InstrValid  = queueValid;
  assign Instruction = queueValid ? headEntry.instr   : NOP_INSTR;
  assign PCPlus4     = queueValid ? headEntry.pcPlus4 : 32'h0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a behavioural instruction memory and an output scoreboard.
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk;
  logic        Reset;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Stall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemData = 32'h0;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;

  int checks;
  int failures;

  logic        memAuto;
  logic        manualAck;
  int          memLat;
  int          waitCnt = 0;
  logic [63:0] sb [$];

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .Stall       (Stall),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemAck      (MemAck),
    .MemData     (MemData),
    .InstrValid  (InstrValid),
    .Instruction (Instruction),
    .PCPlus4     (PCPlus4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  // Memory: auto mode acks after memLat idle cycles; manual mode follows manualAck directly.
  always @(negedge Clk) begin
    if (!memAuto) begin
      waitCnt = 0;
      MemAck  = manualAck;
      MemData = instrOf(MemAddr);
    end else if (MemReq) begin
      if (waitCnt >= memLat) begin
        MemAck  = 1'b1;
        MemData = instrOf(MemAddr);
        waitCnt = 0;
      end else begin
        MemAck  = 1'b0;
        waitCnt = waitCnt + 1;
      end
    end else begin
      MemAck  = 1'b0;
      waitCnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic expectFetch(input logic [31:0] addr);
    sb.push_back({instrOf(addr), addr + 32'd4});
  endtask

  // One clock: observe consumed head at the falling edge, then step past the rising edge.
  task automatic cyc();
    logic [63:0] exp;
    @(negedge Clk);
    if (!Reset) begin
      checks++;
      assert (int'(dut.queueCount) <= DEPTH) else begin
        failures++;
        $error("FAIL count_bound obs=%0d exp<=%0d", dut.queueCount, DEPTH);
      end
    end
    if (InstrValid && !Stall && !Redirect && sb.size() > 0) begin
      exp = sb.pop_front();
      check("head_instr", Instruction, exp[63:32]);
      check("head_pcplus4", PCPlus4, exp[31:0]);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input int maxCyc);
    int n = 0;
    while (sb.size() > 0 && n < maxCyc) begin
      cyc();
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout obs=%0d exp=0 pending", sb.size());
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    Reset      = 1'b1;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    Stall      = 1'b0;
    memAuto    = 1'b1;
    manualAck  = 1'b0;
    memLat     = 0;
    #2;
    check("rst_memreq", {31'b0, MemReq}, 32'd0);
    check("rst_valid", {31'b0, InstrValid}, 32'd0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_pcplus4", PCPlus4, 32'h0);
    check("rst_memaddr", MemAddr, RESET_PC);

    // Zero-wait memory, back-to-back fetch from RESET_PC
    for (int i = 0; i < 4; i++) expectFetch(32'(i * 4));
    cyc();
    Reset = 1'b0;
    cyc();
    check("t1_memreq_c1", {31'b0, MemReq}, 32'd1);
    check("t1_memaddr_c1", MemAddr, 32'h0);
    check("t1_valid_c1", {31'b0, InstrValid}, 32'd0);
    cyc();
    check("t1_valid_c2", {31'b0, InstrValid}, 32'd1);
    check("t1_memaddr_c2", MemAddr, 32'h4);
    drain(20);

    // Stall fills the queue and stops requests
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) expectFetch(32'h10 + 32'(i * 4));
    repeat (10) cyc();
    check("t2_count_full", 32'(dut.queueCount), 32'd4);
    check("t2_memreq_full", {31'b0, MemReq}, 32'd0);
    check("t2_valid_full", {31'b0, InstrValid}, 32'd1);
    Stall = 1'b0;
    cyc();
    check("t2_count_after_pop", 32'(dut.queueCount), 32'd3);
    check("t2_memreq_idle", {31'b0, MemReq}, 32'd0);
    cyc();
    check("t2_memreq_reissue", {31'b0, MemReq}, 32'd1);
    check("t2_memaddr_reissue", MemAddr, 32'h20);
    drain(20);

    // Redirect while waiting; stale reply arrives three cycles later
    memAuto   = 1'b0;
    manualAck = 1'b0;
    Reset     = 1'b1;
    cyc();
    Reset = 1'b0;
    cyc();
    check("t3_memaddr_pre", MemAddr, 32'h0);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0100;
    cyc();
    Redirect = 1'b0;
    check("t3_memreq_discard", {31'b0, MemReq}, 32'd1);
    check("t3_memaddr_stale", MemAddr, 32'h0);
    check("t3_valid_flushed", {31'b0, InstrValid}, 32'd0);
    cyc();
    cyc();
    manualAck = 1'b1;
    check("t3_valid_wait", {31'b0, InstrValid}, 32'd0);
    cyc();
    check("t3_memaddr_new", MemAddr, 32'h100);
    check("t3_valid_dropped", {31'b0, InstrValid}, 32'd0);
    expectFetch(32'h100);
    cyc();
    manualAck = 1'b0;
    check("t3_valid_new", {31'b0, InstrValid}, 32'd1);
    drain(5);

    // Redirect coinciding with ack while stalled
    Stall     = 1'b1;
    manualAck = 1'b1;
    cyc();
    cyc();
    check("t4_count_pre", 32'(dut.queueCount), 32'd2);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0200;
    cyc();
    Redirect  = 1'b0;
    Stall     = 1'b0;
    manualAck = 1'b0;
    check("t4_valid", {31'b0, InstrValid}, 32'd0);
    check("t4_count", 32'(dut.queueCount), 32'd0);
    check("t4_instr_nop", Instruction, 32'h0);
    check("t4_pcplus4_zero", PCPlus4, 32'h0);
    check("t4_memaddr", MemAddr, 32'h200);
    check("t4_memreq", {31'b0, MemReq}, 32'd1);
    expectFetch(32'h200);
    cyc();
    manualAck = 1'b1;
    cyc();
    manualAck = 1'b0;
    drain(5);

    // Fetch across the top of the address space
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    cyc();
    Redirect  = 1'b0;
    manualAck = 1'b1;
    check("t5_memaddr_stale", MemAddr, 32'h204);
    check("t5_valid", {31'b0, InstrValid}, 32'd0);
    cyc();
    check("t5_memaddr_top", MemAddr, 32'hFFFF_FFFC);
    sb.push_back({instrOf(32'hFFFF_FFFC), 32'h0});
    expectFetch(32'h0);
    cyc();
    check("t5_memaddr_wrap", MemAddr, 32'h0);
    cyc();
    manualAck = 1'b0;
    check("t5_memaddr_after", MemAddr, 32'h4);
    drain(5);

    // Asynchronous reset mid-request with slow memory; late ack must be ignored
    memAuto = 1'b1;
    memLat  = 5;
    cyc();
    cyc();
    check("t6_memreq_pending", {31'b0, MemReq}, 32'd1);
    check("t6_valid_pending", {31'b0, InstrValid}, 32'd0);
    #2;
    Reset     = 1'b1;
    memAuto   = 1'b0;
    manualAck = 1'b1;
    #1;
    check("t6_async_memreq", {31'b0, MemReq}, 32'd0);
    check("t6_async_memaddr", MemAddr, RESET_PC);
    check("t6_async_valid", {31'b0, InstrValid}, 32'd0);
    check("t6_async_instr", Instruction, 32'h0);
    check("t6_async_pcplus4", PCPlus4, 32'h0);
    cyc();
    cyc();
    Reset = 1'b0;
    cyc();
    manualAck = 1'b0;
    check("t6_restart_memreq", {31'b0, MemReq}, 32'd1);
    check("t6_restart_memaddr", MemAddr, RESET_PC);
    check("t6_late_ack_valid", {31'b0, InstrValid}, 32'd0);
    check("t6_late_ack_count", 32'(dut.queueCount), 32'd0);
    memAuto = 1'b1;
    memLat  = 1;
    expectFetch(RESET_PC);
    expectFetch(RESET_PC + 32'd4);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
